// File: rtl/cvp14_pkg.sv
// ---------------------------------------------------------------------------
// cvp14_pkg
// Shared definitions for the memory arbiter slice:
//   - bus widths that do not depend on any opcode (16-bit words/addresses)
//   - default burst length (one full vector register)
//   - arbiter FSM state encoding
//   - latched transfer context record and word-count helper
// No ports (package).
// ---------------------------------------------------------------------------
package cvp14_pkg;

  localparam int BUS_W         = 16;
  localparam int BURST_LEN_DEF = 16;
  localparam int OFFSET_W      = 5;

  // Binary-encoded FSM states.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_XFER    = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  typedef logic [BUS_W-1:0] wordT;

  // Everything about the winning request that must stay stable for the
  // whole transfer, independent of what the requester does afterwards.
  typedef struct packed {
    logic owner;   // 0 = core, 1 = host loader
    logic burst;
    logic wrEn;
    wordT addr;
  } xferCtxT;

  // Offset value of the final word of a transfer.
  function automatic logic [OFFSET_W-1:0] lastOffset(input logic burst,
                                                     input int   burstLen);
    return burst ? OFFSET_W'(burstLen - 1) : '0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter: holds the "last granted" pointer and decides
// the winner among two requesters. The pointer only moves when the owning
// transfer has finished (Update), so a long burst does not disturb fairness.
// Ports:
//   Clk, Reset_n     clock, asynchronous active-low reset
//   Req0, Req1       raw requests
//   Update           load the pointer with UpdateId this cycle
//   UpdateId         requester that has just been served
//   Winner           requester that would win if granted now
//   AnyReq           at least one request is pending
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Req0,
  input  logic Req1,
  input  logic Update,
  input  logic UpdateId,
  output logic Winner,
  output logic AnyReq
);

  logic lastGnt;

  // Reset points at requester 1 so that requester 0 wins the first tie.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lastGnt <= 1'b1;
    end else if (Update) begin
      lastGnt <= UpdateId;
    end
  end

  always_comb begin
    AnyReq = Req0 | Req1;
    if (Req0 && Req1) begin
      Winner = ~lastGnt;
    end else begin
      Winner = Req1;
    end
  end

endmodule

// File: rtl/mem_arb16.sv
// ---------------------------------------------------------------------------
// mem_arb16
// Two-requester memory bus arbiter with single-word and burst transfers.
// Requester 0 is the processor core, requester 1 the host loader. Once a
// request wins it owns the bus until every word is done (bus lock), then a
// one-cycle RELEASE separates it from the next grant.
// Ports:
//   Clk, Reset_n              clock, asynchronous active-low reset
//   Req/Burst/WrEn/Addr/WData requester 0 and 1 transfer requests
//   Gnt0/Gnt1                 bus ownership
//   Ack0/Ack1                 one pulse per completed word
//   RData                     read data, valid while a read Ack is high
//   Addr, RD, WR, DataOut     memory side address, strobes and write data
//   DataIn                    memory read data, RD_LAT cycles after RD
// ---------------------------------------------------------------------------
module mem_arb16
  import cvp14_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int RD_LAT    = 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Req0,
  input  logic             Req1,
  input  logic             Burst0,
  input  logic             Burst1,
  input  logic             WrEn0,
  input  logic             WrEn1,
  input  logic [BUS_W-1:0] Addr0,
  input  logic [BUS_W-1:0] Addr1,
  input  logic [BUS_W-1:0] WData0,
  input  logic [BUS_W-1:0] WData1,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic             Ack0,
  output logic             Ack1,
  output logic [BUS_W-1:0] RData,
  output logic [BUS_W-1:0] Addr,
  output logic             RD,
  output logic             WR,
  output logic [BUS_W-1:0] DataOut,
  input  logic [BUS_W-1:0] DataIn
);

  logic [1:0]          state, stateNext;
  xferCtxT             ctx, ctxNext;
  logic [OFFSET_W-1:0] offset, offsetNext;
  logic [RD_LAT-1:0]   rdPipe;

  logic winner;
  logic anyReq;
  logic ptrUpdate;
  logic lastWord;
  logic drainDone;
  logic inXfer;
  logic owned;
  logic writeAck;
  logic readAck;
  wordT curAddr;

  // -------------------------------------------------------------------------
  // Round-robin pointer and winner selection
  // -------------------------------------------------------------------------
  assign ptrUpdate = (state == ST_RELEASE);

  rr_arb2 uArb (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Req0     (Req0),
    .Req1     (Req1),
    .Update   (ptrUpdate),
    .UpdateId (ctx.owner),
    .Winner   (winner),
    .AnyReq   (anyReq)
  );

  // -------------------------------------------------------------------------
  // Transfer bookkeeping
  // -------------------------------------------------------------------------
  assign lastWord = (offset == lastOffset(ctx.burst, BURST_LEN));

  // Reads in flight: stage 0 captures the RD strobe, the head stage lines
  // up with valid DataIn.
  assign readAck = rdPipe[RD_LAT-1];

  // DRAIN may end only when the head stage carries the last read and no
  // younger read is still travelling down the pipe.
  always_comb begin
    drainDone = rdPipe[RD_LAT-1];
    for (int i = 0; i < RD_LAT - 1; i++) begin
      if (rdPipe[i]) begin
        drainDone = 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    stateNext  = state;
    ctxNext    = ctx;
    offsetNext = offset;
    case (state)
      ST_IDLE: begin
        if (anyReq) begin
          ctxNext.owner = winner;
          ctxNext.burst = winner ? Burst1 : Burst0;
          ctxNext.wrEn  = winner ? WrEn1  : WrEn0;
          ctxNext.addr  = winner ? Addr1  : Addr0;
          offsetNext    = '0;
          stateNext     = ST_XFER;
        end
      end
      ST_XFER: begin
        // Requests are not looked at here: the transfer is locked.
        if (lastWord) begin
          stateNext = ctx.wrEn ? ST_RELEASE : ST_DRAIN;
        end else begin
          offsetNext = offset + OFFSET_W'(1);
        end
      end
      ST_DRAIN: begin
        if (drainDone) begin
          stateNext = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        stateNext = ST_IDLE;
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= ST_IDLE;
      ctx    <= '0;
      offset <= '0;
    end else begin
      state  <= stateNext;
      ctx    <= ctxNext;
      offset <= offsetNext;
    end
  end

  // Clearing the pipe on reset drops any read still in flight, so an
  // aborted burst produces no late Ack.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rdPipe <= '0;
    end else begin
      rdPipe[0] <= RD;
      for (int i = 1; i < RD_LAT; i++) begin
        rdPipe[i] <= rdPipe[i-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded from registered state, so an asynchronous reset
  // silences the bus in the same cycle.
  // -------------------------------------------------------------------------
  assign inXfer  = (state == ST_XFER);
  assign owned   = (state == ST_XFER) || (state == ST_DRAIN);

  // 16-bit add wraps naturally past 0xFFFF.
  assign curAddr = ctx.addr + wordT'(offset);

  always_comb begin
    Gnt0     = owned & ~ctx.owner;
    Gnt1     = owned &  ctx.owner;
    WR       = inXfer &  ctx.wrEn;
    RD       = inXfer & ~ctx.wrEn;
    writeAck = WR;
    Ack0     = (writeAck | readAck) & ~ctx.owner;
    Ack1     = (writeAck | readAck) &  ctx.owner;
    Addr     = inXfer ? curAddr : '0;
    // Write data comes straight from the owner; each word is consumed by
    // the Ack pulse of the same cycle.
    DataOut  = WR ? (ctx.owner ? WData1 : WData0) : '0;
    RData    = readAck ? DataIn : '0;
  end

endmodule

// File: tb/tb_mem_arb16.sv
// ---------------------------------------------------------------------------
// tb_mem_arb16
// Directed bench for mem_arb16: a table of single-word transfers followed by
// hand-written burst, lock, wrap, contention and reset-abort sequences.
// The memory model answers a read with addr ^ 0xA5A5 one cycle after RD.
// ---------------------------------------------------------------------------
module tb_mem_arb16;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Req0 = 1'b0, Req1 = 1'b0;
  logic        Burst0 = 1'b0, Burst1 = 1'b0;
  logic        WrEn0 = 1'b0, WrEn1 = 1'b0;
  logic [15:0] Addr0 = '0, Addr1 = '0;
  logic [15:0] WData0 = '0, WData1 = '0;
  logic        Gnt0, Gnt1, Ack0, Ack1, RD, WR;
  logic [15:0] RData, Addr, DataOut;
  logic [15:0] DataIn = '0;

  int errors = 0;
  int checks = 0;

  mem_arb16 #(.BURST_LEN(16), .RD_LAT(1)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Req0    (Req0),
    .Req1    (Req1),
    .Burst0  (Burst0),
    .Burst1  (Burst1),
    .WrEn0   (WrEn0),
    .WrEn1   (WrEn1),
    .Addr0   (Addr0),
    .Addr1   (Addr1),
    .WData0  (WData0),
    .WData1  (WData1),
    .Gnt0    (Gnt0),
    .Gnt1    (Gnt1),
    .Ack0    (Ack0),
    .Ack1    (Ack1),
    .RData   (RData),
    .Addr    (Addr),
    .RD      (RD),
    .WR      (WR),
    .DataOut (DataOut),
    .DataIn  (DataIn)
  );

  always #5 Clk = ~Clk;

  // Memory model with one cycle of read latency.
  always @(posedge Clk) begin
    DataIn <= RD ? (Addr ^ 16'hA5A5) : 16'h0000;
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        who;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] expData;  // DataOut for writes, RData for reads
  } vecT;

  vecT vecs[6];

  // One single-word transfer from IDLE back to IDLE.
  task automatic runSingle(input vecT v);
    @(negedge Clk);
    if (!v.who) begin
      Req0 = 1'b1; Burst0 = 1'b0; WrEn0 = v.wr; Addr0 = v.addr; WData0 = v.wdata;
    end else begin
      Req1 = 1'b1; Burst1 = 1'b0; WrEn1 = v.wr; Addr1 = v.addr; WData1 = v.wdata;
    end
    @(negedge Clk);  // XFER
    Req0 = 1'b0; Req1 = 1'b0;
    chk1("single_gnt_own", v.who ? Gnt1 : Gnt0, 1'b1);
    chk1("single_gnt_other", v.who ? Gnt0 : Gnt1, 1'b0);
    chk16("single_addr", Addr, v.addr);
    chk1("single_wr", WR, v.wr);
    chk1("single_rd", RD, ~v.wr);
    if (v.wr) begin
      chk16("single_dataout", DataOut, v.expData);
      chk1("single_wack", v.who ? Ack1 : Ack0, 1'b1);
    end else begin
      chk1("single_rack_early", v.who ? Ack1 : Ack0, 1'b0);
      @(negedge Clk);  // DRAIN
      chk1("single_rack", v.who ? Ack1 : Ack0, 1'b1);
      chk16("single_rdata", RData, v.expData);
      chk1("single_drain_rd", RD, 1'b0);
    end
    @(negedge Clk);  // RELEASE
    chk1("single_rel_gnt", Gnt0 | Gnt1, 1'b0);
    chk1("single_rel_strobe", RD | WR, 1'b0);
    chk1("single_rel_ack", Ack0 | Ack1, 1'b0);
    @(negedge Clk);  // IDLE
    chk1("single_idle_gnt", Gnt0 | Gnt1, 1'b0);
    $display("txn single who=%0d wr=%0d addr=%h data=%h", v.who, v.wr, v.addr, v.expData);
  endtask

  logic [15:0] expA;
  logic        order [3];
  int          nGrants;
  logic        overlap, prevG0, prevG1;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 16'h0040, 16'hBEEF, 16'hBEEF};
    vecs[1] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 16'hB791};
    vecs[2] = '{1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'h0001};
    vecs[3] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'hA5A5};
    vecs[4] = '{1'b0, 1'b0, 16'h5A5A, 16'h0000, 16'hFFFF};
    vecs[5] = '{1'b0, 1'b1, 16'h0400, 16'h1357, 16'h1357};

    // Reset state, with a request held to show it is ignored.
    Req0 = 1'b1;
    @(negedge Clk);
    chk1("rst_gnt0", Gnt0, 1'b0);
    chk1("rst_gnt1", Gnt1, 1'b0);
    chk1("rst_ack", Ack0 | Ack1, 1'b0);
    chk1("rst_rd", RD, 1'b0);
    chk1("rst_wr", WR, 1'b0);
    chk16("rst_addr", Addr, 16'h0000);
    chk16("rst_dataout", DataOut, 16'h0000);
    chk16("rst_rdata", RData, 16'h0000);
    Req0 = 1'b0;
    Reset_n = 1'b1;
    $display("txn reset");

    for (int i = 0; i < 5; i++) begin
      runSingle(vecs[i]);
    end

    // Burst read by requester 1 with Req1 dropped after word 3 and
    // Req0 raised meanwhile: bus stays locked until RELEASE.
    @(negedge Clk);
    Req1 = 1'b1; Burst1 = 1'b1; WrEn1 = 1'b0; Addr1 = 16'h0100;
    for (int k = 0; k < 16; k++) begin
      @(negedge Clk);
      expA = 16'h0100 + 16'(k);
      chk1("burst_rd", RD, 1'b1);
      chk16("burst_addr", Addr, expA);
      chk1("burst_gnt1", Gnt1, 1'b1);
      chk1("burst_gnt0", Gnt0, 1'b0);
      chk1("burst_ack1", Ack1, (k != 0));
      if (k != 0) begin
        chk16("burst_rdata", RData, (expA - 16'h0001) ^ 16'hA5A5);
      end
      if (k == 3) begin
        Req1 = 1'b0;
        Req0 = 1'b1; Burst0 = 1'b0; WrEn0 = 1'b1; Addr0 = 16'h0200; WData0 = 16'h55AA;
      end
    end
    @(negedge Clk);  // DRAIN
    chk1("burst_drain_ack", Ack1, 1'b1);
    chk16("burst_last_rdata", RData, 16'hA4AA);
    chk1("burst_drain_rd", RD, 1'b0);
    chk1("lock_drain_gnt0", Gnt0, 1'b0);
    @(negedge Clk);  // RELEASE
    chk1("lock_rel_gnt0", Gnt0, 1'b0);
    chk1("lock_rel_gnt1", Gnt1, 1'b0);
    @(negedge Clk);  // IDLE
    chk1("lock_idle_gnt0", Gnt0, 1'b0);
    @(negedge Clk);  // XFER for requester 0
    Req0 = 1'b0;
    chk1("lock_gnt0", Gnt0, 1'b1);
    chk1("lock_wr", WR, 1'b1);
    chk16("lock_addr", Addr, 16'h0200);
    chk16("lock_dataout", DataOut, 16'h55AA);
    chk1("lock_ack0", Ack0, 1'b1);
    @(negedge Clk);
    @(negedge Clk);
    $display("txn burst read 0x0100 with lock, then core write 0x0200");

    // Wrapping burst write; requester updates WData0 after each Ack.
    @(negedge Clk);
    Req0 = 1'b1; Burst0 = 1'b1; WrEn0 = 1'b1; Addr0 = 16'hFFF8; WData0 = 16'h3000;
    for (int k = 0; k < 16; k++) begin
      @(negedge Clk);
      Req0 = 1'b0;
      expA = 16'hFFF8 + 16'(k);
      chk1("wrap_wr", WR, 1'b1);
      chk16("wrap_addr", Addr, expA);
      chk16("wrap_dataout", DataOut, 16'h3000 + 16'(k));
      chk1("wrap_ack0", Ack0, 1'b1);
      WData0 = 16'h3000 + 16'(k + 1);
    end
    @(negedge Clk);  // RELEASE
    chk1("wrap_rel_gnt", Gnt0, 1'b0);
    chk1("wrap_rel_wr", WR, 1'b0);
    @(negedge Clk);
    $display("txn wrap burst write 0xFFF8");

    // Contention right after reset: expected order 0, 1, 0.
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    Req0 = 1'b1; Burst0 = 1'b0; WrEn0 = 1'b1; Addr0 = 16'h0A00; WData0 = 16'h000A;
    Req1 = 1'b1; Burst1 = 1'b0; WrEn1 = 1'b1; Addr1 = 16'h0B00; WData1 = 16'h000B;
    nGrants = 0; overlap = 1'b0; prevG0 = 1'b0; prevG1 = 1'b0;
    for (int c = 0; c < 40 && nGrants < 3; c++) begin
      @(negedge Clk);
      if (Gnt0 && Gnt1) overlap = 1'b1;
      if (Gnt0 && !prevG0 && nGrants < 3) begin order[nGrants] = 1'b0; nGrants++; end
      if (Gnt1 && !prevG1 && nGrants < 3) begin order[nGrants] = 1'b1; nGrants++; end
      prevG0 = Gnt0; prevG1 = Gnt1;
    end
    Req0 = 1'b0; Req1 = 1'b0;
    chk16("cont_grants", 16'(nGrants), 16'd3);
    if (nGrants == 3) begin
      chk1("cont_order0", order[0], 1'b0);
      chk1("cont_order1", order[1], 1'b1);
      chk1("cont_order2", order[2], 1'b0);
    end
    chk1("cont_overlap", overlap, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    $display("txn contention grants=%0d", nGrants);

    // Reset in the 5th cycle of a burst read, then a normal request.
    @(negedge Clk);
    Req0 = 1'b1; Burst0 = 1'b1; WrEn0 = 1'b0; Addr0 = 16'h0300;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      Req0 = 1'b0;
      chk1("abort_rd", RD, 1'b1);
      chk16("abort_addr", Addr, 16'h0300 + 16'(k));
    end
    Reset_n = 1'b0;
    #1;
    chk1("abort_rd_now", RD, 1'b0);
    chk1("abort_wr_now", WR, 1'b0);
    chk1("abort_gnt_now", Gnt0 | Gnt1, 1'b0);
    chk1("abort_ack_now", Ack0 | Ack1, 1'b0);
    chk16("abort_addr_now", Addr, 16'h0000);
    @(negedge Clk);
    chk1("abort_held_rd", RD, 1'b0);
    chk1("abort_held_ack", Ack0, 1'b0);
    Reset_n = 1'b1;
    $display("txn reset abort of burst 0x0300");
    runSingle(vecs[5]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
